// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared constants and types for the 16-bit RISC core
// Purpose: machine widths, reset PC, opcode encodings (instr[15:12]) and
//          the fetch-stage FSM state type.
package risc_pkg;

    localparam int          ADDR_W   = 16;
    localparam int          INSTR_W  = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // Opcode field lives in instr[15:12]
    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_SUB = 4'h1;
    localparam logic [3:0] OPC_AND = 4'h2;
    localparam logic [3:0] OPC_OR  = 4'h3;
    localparam logic [3:0] OPC_XOR = 4'h4;
    localparam logic [3:0] OPC_SHL = 4'h5;
    localparam logic [3:0] OPC_SHR = 4'h6;
    localparam logic [3:0] OPC_LDI = 4'h7;
    localparam logic [3:0] OPC_LD  = 4'h8;
    localparam logic [3:0] OPC_ST  = 4'h9;
    localparam logic [3:0] OPC_BEQ = 4'hA;
    localparam logic [3:0] OPC_BNE = 4'hB;
    localparam logic [3:0] OPC_JMP = 4'hC;
    localparam logic [3:0] OPC_JAL = 4'hD;
    localparam logic [3:0] OPC_JR  = 4'hE;
    localparam logic [3:0] OPC_NOP = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order instruction buffer for the fetch stage
// Purpose: DEPTH-entry synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push        write i_push_data at the tail
//   i_pop         retire the head entry (caller only pops when non-empty)
//   i_flush       empty the buffer; a same-cycle pop is simply subsumed
//   o_count       number of valid entries (0..DEPTH)
//   o_head        head entry, read straight from storage registers
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
            end
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (i_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (i_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
            end
        end
    end

    assign o_count = r_count;
    // Pointers wrap naturally because DEPTH is a power of two
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, request credit and redirect logic of the fetch stage
// Purpose: issues word fetches to a synchronous instruction memory, buffers
//          in-order responses and hands them to decode over valid/ready.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   fetch_en                       allow new requests (IDLE <-> RUN)
//   imem_req_valid/ready/addr      request channel, addr = pc
//   imem_rsp_valid/data            in-order response channel
//   instr_valid/ready/data/pc      buffer head towards decode
//   redirect_valid/pc              flush and restart fetch at redirect_pc
module instr_fetch_unit #(
    parameter int                ADDR_W   = risc_pkg::ADDR_W,
    parameter int                INSTR_W  = risc_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = risc_pkg::RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    import risc_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    // Stale responses can pile up across back-to-back redirects, so the
    // drop counter gets headroom beyond DEPTH.
    localparam int DROP_W = CNT_W + 3;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    fetch_state_t         r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_tag_pc;      // address of the oldest kept outstanding request
    logic [CNT_W-1:0]     r_keep_cnt;
    logic [DROP_W-1:0]    r_drop_cnt;

    logic [CNT_W-1:0]     w_fifo_cnt;
    logic [ADDR_W+INSTR_W-1:0] w_head;
    logic                 w_pop;
    logic [CNT_W:0]       w_credit_used;
    logic                 w_req_fire;
    logic                 w_dropping;
    logic                 w_rsp_keep;
    logic                 w_push;
    logic [ADDR_W-1:0]    w_redirect_pc;

    assign instr_valid = (w_fifo_cnt != '0);
    assign w_pop       = instr_valid & instr_ready;

    // A pop this cycle frees a slot in time for the response to land in it
    assign w_credit_used = {1'b0, r_keep_cnt} + {1'b0, w_fifo_cnt} - (CNT_W+1)'(w_pop);

    assign imem_req_valid = (r_state == RUN) & ~redirect_valid
                          & (w_credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_dropping    = (r_drop_cnt != '0);
    assign w_rsp_keep    = imem_rsp_valid & ~w_dropping;
    assign w_push        = w_rsp_keep & ~redirect_valid;
    assign w_redirect_pc = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (fetch_en)  r_state <= RUN;
                RUN:     if (!fetch_en) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_tag_pc   <= RESET_PC;
            r_keep_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_pc;
            r_tag_pc   <= w_redirect_pc;
            r_keep_cnt <= '0;
            // Every request still outstanding becomes stale; a response
            // arriving right now retires one of them.
            r_drop_cnt <= r_drop_cnt + DROP_W'(r_keep_cnt) - DROP_W'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + ADDR_W'(2);
            end
            if (w_rsp_keep) begin
                r_tag_pc <= r_tag_pc + ADDR_W'(2);
            end
            if (imem_rsp_valid && w_dropping) begin
                r_drop_cnt <= r_drop_cnt - DROP_W'(1);
            end
            r_keep_cnt <= r_keep_cnt + CNT_W'(w_req_fire) - CNT_W'(w_rsp_keep);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_tag_pc, imem_rsp_data}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_fifo_cnt),
        .o_head      (w_head)
    );

    assign instr_pc   = w_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr_data = w_head[INSTR_W-1:0];

endmodule
